// File: rtl/regfile_arb_pkg.sv
// Shared widths and index helpers for the register-file write arbiter.
// Pure declarations: no latency, no flow control.
package regfile_arb_pkg;
   localparam int ADDR_W        = 3;
   localparam int DATA_W        = 32;
   localparam int NUM_PORTS_DEF = 6;
   localparam int NUM_REQ_DEF   = 8;

   function automatic int idx_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   typedef logic [idx_w(NUM_REQ_DEF)-1:0] req_idx_t;
endpackage

// File: rtl/regfile_arb_pick.sv
// Round-robin pick of up to NUM_PORTS distinct-address writes, packed onto ports in scan order.
// Purely combinational; requesters that are not granted simply see no grant this cycle.
module regfile_arb_pick
   import regfile_arb_pkg::*;
#(
   parameter  int NUM_REQ   = 8,
   parameter  int NUM_PORTS = 6,
   parameter  int ADDR_W_P  = 3,
   localparam int IDX_W     = idx_w(NUM_REQ)
) (
   input  logic [IDX_W-1:0]           rr_ptr,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*ADDR_W_P-1:0] req_addr,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       any_grant,
   output logic [IDX_W-1:0]           last_idx,
   output logic [NUM_PORTS-1:0]       port_vld,
   output logic [NUM_PORTS*IDX_W-1:0] port_src
);
   int                        n_grant;
   int                        idx;
   logic [(1<<ADDR_W_P)-1:0]  addr_used;
   logic [ADDR_W_P-1:0]       a;

   always_comb begin
      grant     = '0;
      port_vld  = '0;
      port_src  = '0;
      last_idx  = rr_ptr;
      n_grant   = 0;
      idx       = 0;
      addr_used = '0;
      a         = '0;
      // One pass starting at rr_ptr; an address claimed earlier in the pass blocks later requesters.
      for (int s = 0; s < NUM_REQ; s++) begin
         idx = int'(rr_ptr) + s;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         a = req_addr[idx*ADDR_W_P +: ADDR_W_P];
         if (req_valid[idx] && (n_grant < NUM_PORTS) && !addr_used[a]) begin
            grant[idx]                          = 1'b1;
            addr_used[a]                        = 1'b1;
            port_vld[n_grant]                   = 1'b1;
            port_src[n_grant*IDX_W +: IDX_W]    = IDX_W'(idx);
            last_idx                            = IDX_W'(idx);
            n_grant                             = n_grant + 1;
         end
      end
   end

   assign any_grant = |grant;
endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares register-file write ports among requesters; grant is combinational, port bundle lands 1 edge later.
// Ungranted requesters hold until req_ready; REGFILE_ARB_STATS_EN adds the saturating conflict counter.
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int NUM_REQ   = NUM_REQ_DEF,
   parameter int NUM_PORTS = NUM_PORTS_DEF,
   parameter int log2regs  = ADDR_W,
   parameter int size      = DATA_W
) (
   input  logic                          CGRA_Clock,
   input  logic                          CGRA_Reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*log2regs-1:0]   req_addr,
   input  logic [NUM_REQ*size-1:0]       req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_PORTS-1:0]          WE,
   output logic [NUM_PORTS*log2regs-1:0] address_in,
   output logic [NUM_PORTS*size-1:0]     in,
   output logic [15:0]                   conflict_cnt
);
   localparam int IDX_W = idx_w(NUM_REQ);

   logic [NUM_REQ-1:0]            grant;
   logic                          any_grant;
   logic [IDX_W-1:0]              last_idx;
   logic [NUM_PORTS-1:0]          port_vld;
   logic [NUM_PORTS*IDX_W-1:0]    port_src;

   logic [IDX_W-1:0]              rr_ptr_d, rr_ptr_q;
   logic [NUM_PORTS-1:0]          we_d, we_q;
   logic [NUM_PORTS*log2regs-1:0] address_in_d, address_in_q;
   logic [NUM_PORTS*size-1:0]     in_d, in_q;
   int                            src;

   regfile_arb_pick #(
      .NUM_REQ   (NUM_REQ),
      .NUM_PORTS (NUM_PORTS),
      .ADDR_W_P  (log2regs)
   ) u_pick (
      .rr_ptr    (rr_ptr_q),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .grant     (grant),
      .any_grant (any_grant),
      .last_idx  (last_idx),
      .port_vld  (port_vld),
      .port_src  (port_src)
   );

   // Grants in a reset cycle are discarded, so ready must not advertise them.
   assign req_ready = CGRA_Reset ? '0 : grant;

   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      we_d         = port_vld;
      address_in_d = '0;
      in_d         = '0;
      src          = 0;
      if (any_grant)
         rr_ptr_d = (int'(last_idx) == NUM_REQ - 1) ? '0 : last_idx + 1'b1;
      for (int k = 0; k < NUM_PORTS; k++) begin
         if (port_vld[k]) begin
            src = int'(port_src[k*IDX_W +: IDX_W]);
            address_in_d[k*log2regs +: log2regs] = req_addr[src*log2regs +: log2regs];
            in_d[k*size +: size]                 = req_data[src*size +: size];
         end
      end
   end

   always_ff @(posedge CGRA_Clock) begin
      if (CGRA_Reset) begin
         rr_ptr_q     <= '0;
         we_q         <= '0;
         address_in_q <= '0;
         in_q         <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         we_q         <= we_d;
         address_in_q <= address_in_d;
         in_q         <= in_d;
      end
   end

   assign WE         = we_q;
   assign address_in = address_in_q;
   assign in         = in_q;

`ifdef REGFILE_ARB_STATS_EN
   logic [15:0] conflict_cnt_d, conflict_cnt_q;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if ((|(req_valid & ~grant)) && (conflict_cnt_q != 16'hFFFF))
         conflict_cnt_d = conflict_cnt_q + 16'd1;
   end

   always_ff @(posedge CGRA_Clock) begin
      if (CGRA_Reset) conflict_cnt_q <= '0;
      else            conflict_cnt_q <= conflict_cnt_d;
   end

   assign conflict_cnt = conflict_cnt_q;
`else
   assign conflict_cnt = '0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed table plus hand sequences for the register-file write arbiter.
module tb_regfile_write_arbiter;
   localparam int NR = 8;
   localparam int NP = 6;
   localparam int AW = 3;
   localparam int DW = 32;
`ifdef REGFILE_ARB_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic             CGRA_Clock = 1'b0;
   logic             CGRA_Reset;
   logic [NR-1:0]    req_valid;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    req_ready;
   logic [NP-1:0]    WE;
   logic [NP*AW-1:0] address_in;
   logic [NP*DW-1:0] in;
   logic [15:0]      conflict_cnt;

   regfile_write_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .log2regs(AW), .size(DW)) dut (
      .CGRA_Clock   (CGRA_Clock),
      .CGRA_Reset   (CGRA_Reset),
      .req_valid    (req_valid),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .WE           (WE),
      .address_in   (address_in),
      .in           (in),
      .conflict_cnt (conflict_cnt)
   );

   always #5 CGRA_Clock = ~CGRA_Clock;

   typedef struct {
      logic [7:0] valid;
      int         addr [8];
      logic [7:0] ready;
      logic [5:0] we;
      int         src  [6];
      int         rr;
   } vec_t;

   vec_t vt [10];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_unique();
      int ok;
      ok = 1;
      for (int j = 0; j < NP; j++)
         for (int k = j + 1; k < NP; k++)
            if (WE[j] && WE[k] && address_in[j*AW +: AW] == address_in[k*AW +: AW]) ok = 0;
      chk("we_addr_unique", 256'(ok), 256'd1);
   endtask

   task automatic drive_all(input logic [7:0] v, input logic [2:0] a, input int tag);
      req_valid = v;
      for (int i = 0; i < NR; i++) begin
         req_addr[i*AW +: AW] = a;
         req_data[i*DW +: DW] = 32'(32'hC0DE0000 + tag*256 + i);
      end
   endtask

   initial begin
      logic [NP*AW-1:0] ea;
      logic [NP*DW-1:0] ed;
      int               s;

      vt[0] = '{8'hFF, '{0,1,2,3,4,5,6,7}, 8'h3F, 6'h3F, '{0,1,2,3,4,5}, 6};
      vt[1] = '{8'hC0, '{0,1,2,3,4,5,6,7}, 8'hC0, 6'h03, '{6,7,0,0,0,0}, 0};
      vt[2] = '{8'h24, '{0,0,3,0,0,3,0,0}, 8'h04, 6'h01, '{2,0,0,0,0,0}, 3};
      vt[3] = '{8'h20, '{0,0,3,0,0,3,0,0}, 8'h20, 6'h01, '{5,0,0,0,0,0}, 6};
      vt[4] = '{8'h80, '{0,0,0,0,0,0,0,6}, 8'h80, 6'h01, '{7,0,0,0,0,0}, 0};
      vt[5] = '{8'h00, '{0,0,0,0,0,0,0,6}, 8'h00, 6'h00, '{0,0,0,0,0,0}, 0};
      vt[6] = '{8'h80, '{0,0,0,0,0,0,0,2}, 8'h80, 6'h01, '{7,0,0,0,0,0}, 0};
      vt[7] = '{8'hFF, '{0,0,1,1,2,3,4,5}, 8'hF5, 6'h3F, '{0,2,4,5,6,7}, 0};
      vt[8] = '{8'h0A, '{0,0,1,1,2,3,4,5}, 8'h0A, 6'h03, '{1,3,0,0,0,0}, 4};
      vt[9] = '{8'hFF, '{0,1,2,3,4,5,6,7}, 8'hF3, 6'h3F, '{4,5,6,7,0,1}, 2};

      // Reset with requests pending: ready must stay low.
      CGRA_Reset = 1'b1;
      drive_all(8'hFF, 3'd2, 99);
      repeat (2) @(posedge CGRA_Clock);
      #1;
      chk("reset_ready", 256'(req_ready), 256'd0);
      chk("reset_we", 256'(WE), 256'd0);
      chk("reset_addr", 256'(address_in), 256'd0);
      chk("reset_data", 256'(in), 256'd0);
      chk("reset_rr", 256'(dut.rr_ptr_q), 256'd0);
      chk("reset_cnt", 256'(conflict_cnt), 256'd0);
      CGRA_Reset = 1'b0;

      for (int n = 0; n < 10; n++) begin
         req_valid = vt[n].valid;
         for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW] = vt[n].addr[i][2:0];
            req_data[i*DW +: DW] = 32'(32'hC0DE0000 + n*256 + i);
         end
         ea = '0;
         ed = '0;
         for (int k = 0; k < NP; k++) begin
            if (vt[n].we[k]) begin
               s = vt[n].src[k];
               ea[k*AW +: AW] = vt[n].addr[s][2:0];
               ed[k*DW +: DW] = 32'(32'hC0DE0000 + n*256 + s);
            end
         end
         #2;
         chk($sformatf("v%0d_ready", n), 256'(req_ready), 256'(vt[n].ready));
         @(posedge CGRA_Clock);
         #1;
         chk($sformatf("v%0d_we", n), 256'(WE), 256'(vt[n].we));
         chk($sformatf("v%0d_addr", n), 256'(address_in), 256'(ea));
         chk($sformatf("v%0d_data", n), 256'(in), 256'(ed));
         chk($sformatf("v%0d_rr", n), 256'(dut.rr_ptr_q), 256'(vt[n].rr));
         chk_unique();
      end

      // Reset arriving while three requests are valid and the bundle is busy.
      req_valid = 8'h07;
      for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 3'(i);
      CGRA_Reset = 1'b1;
      #2;
      chk("midreset_ready", 256'(req_ready), 256'd0);
      @(posedge CGRA_Clock);
      #1;
      chk("midreset_we", 256'(WE), 256'd0);
      chk("midreset_addr", 256'(address_in), 256'd0);
      chk("midreset_rr", 256'(dut.rr_ptr_q), 256'd0);
      CGRA_Reset = 1'b0;

      // Everyone on address 4: strict one-per-cycle rotation 0..7.
      drive_all(8'hFF, 3'd4, 50);
      for (int c = 0; c < NR; c++) begin
         #2;
         chk($sformatf("same_ready%0d", c), 256'(req_ready), 256'(8'd1 << c));
         @(posedge CGRA_Clock);
         #1;
         chk($sformatf("same_we%0d", c), 256'(WE), 256'd1);
         chk($sformatf("same_addr%0d", c), 256'(address_in[AW-1:0]), 256'd4);
         chk($sformatf("same_data%0d", c), 256'(in[DW-1:0]), 256'(32'(32'hC0DE0000 + 50*256 + c)));
         chk_unique();
      end
      chk("cnt_after_same4", 256'(conflict_cnt), 256'(STATS ? 8 : 0));

      CGRA_Reset = 1'b1;
      @(posedge CGRA_Clock);
      #1;
      CGRA_Reset = 1'b0;
      chk("cnt_cleared", 256'(conflict_cnt), 256'd0);
      drive_all(8'hFF, 3'd1, 60);
      repeat (10) @(posedge CGRA_Clock);
      #1;
      chk("cnt_10", 256'(conflict_cnt), 256'(STATS ? 10 : 0));

`ifdef REGFILE_ARB_STATS_EN
      repeat (65530) @(posedge CGRA_Clock);
      #1;
      chk("cnt_sat", 256'(conflict_cnt), 256'hFFFF);
      repeat (3) @(posedge CGRA_Clock);
      #1;
      chk("cnt_sat_hold", 256'(conflict_cnt), 256'hFFFF);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
